// File: rtl/cpu6502_pkg.sv
// Shared 6502 definitions: addressing-mode codes, operand sequencer state encoding
// and the ADC opcodes decoded by instruction_control.
package cpu6502_pkg;

  localparam logic [3:0] MODE_IMM   = 4'd0;
  localparam logic [3:0] MODE_ZP    = 4'd1;
  localparam logic [3:0] MODE_ZP_X  = 4'd2;
  localparam logic [3:0] MODE_ZPI   = 4'd3;
  localparam logic [3:0] MODE_ZPI_X = 4'd4;
  localparam logic [3:0] MODE_ZPI_Y = 4'd5;
  localparam logic [3:0] MODE_ABS   = 4'd6;
  localparam logic [3:0] MODE_ABS_X = 4'd7;
  localparam logic [3:0] MODE_ABS_Y = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OP_LO,
    S_OP_HI,
    S_PTR_LO,
    S_PTR_HI,
    S_FIX,
    S_READ,
    S_DONE
  } seq_state_e;

  localparam logic [7:0] OPC_ADC_IMM   = 8'h69;
  localparam logic [7:0] OPC_ADC_ZP    = 8'h65;
  localparam logic [7:0] OPC_ADC_ZP_X  = 8'h75;
  localparam logic [7:0] OPC_ADC_ZPI   = 8'h72;
  localparam logic [7:0] OPC_ADC_ZPI_X = 8'h61;
  localparam logic [7:0] OPC_ADC_ZPI_Y = 8'h71;
  localparam logic [7:0] OPC_ADC_ABS   = 8'h6D;
  localparam logic [7:0] OPC_ADC_ABS_X = 8'h7D;
  localparam logic [7:0] OPC_ADC_ABS_Y = 8'h79;

  function automatic logic mode_legal(input logic [3:0] m);
    return (m <= MODE_ABS_Y);
  endfunction

endpackage

// File: rtl/operand_sequencer_ea_calc.sv
// Address arithmetic for the operand sequencer: zero-page indexing, pointer
// high-byte address, 16-bit indexed add and page-cross detection.
module ea_calc #(
  parameter bit ZP_WRAP = 1'b1
) (
  input  logic [7:0]  zp_base,
  input  logic [7:0]  zp_index,
  input  logic [15:0] ptr,
  input  logic [15:0] abs_base,
  input  logic [7:0]  abs_index,
  output logic [15:0] zp_addr,
  output logic [15:0] ptr_next,
  output logic [15:0] abs_addr,
  output logic        page_cross
);

  always_comb begin
    if (ZP_WRAP) begin
      // ptr high byte is always 0x00 here, so the carry simply drops
      zp_addr  = {8'h00, zp_base + zp_index};
      ptr_next = {ptr[15:8], ptr[7:0] + 8'd1};
    end else begin
      zp_addr  = {8'h00, zp_base} + {8'h00, zp_index};
      ptr_next = ptr + 16'd1;
    end
    abs_addr   = abs_base + {8'h00, abs_index};
    page_cross = (abs_addr[15:8] != abs_base[15:8]);
  end

endmodule

// File: rtl/operand_sequencer.sv
// Resolves a 6502 addressing mode into an effective address and fetches the operand.
// Optional page-cross penalty cycle: define OPERAND_SEQ_PAGE_PENALTY_EN.
//
//  state    | meaning
//  IDLE     | waiting for start
//  OP_LO    | fetch first operand byte at pc
//  OP_HI    | fetch absolute high byte at pc
//  PTR_LO   | read pointer low byte from zero page
//  PTR_HI   | read pointer high byte from zero page
//  FIX      | dummy read at {base_hi, ea_lo} on page cross
//  READ     | read operand at ea
//  DONE     | ea/operand/err valid for one cycle
module operand_sequencer
  import cpu6502_pkg::*;
#(
  parameter bit ZP_WRAP     = 1'b1,
  parameter int ACK_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mode,
  input  logic [15:0] pc,
  input  logic [7:0]  x_reg,
  input  logic [7:0]  y_reg,
  output logic [15:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        pc_inc,
  output logic [15:0] ea,
  output logic [7:0]  operand,
  output logic        busy,
  output logic        done,
  output logic        err
);

`ifdef OPERAND_SEQ_PAGE_PENALTY_EN
  localparam bit PENALTY_EN = 1'b1;
`else
  localparam bit PENALTY_EN = 1'b0;
`endif

  localparam logic [15:0] TMO_LOAD = (ACK_TIMEOUT > 0) ? 16'(ACK_TIMEOUT - 1) : 16'd0;

  seq_state_e  state_q, state_d;
  logic [3:0]  mode_q, mode_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] ptr_q, ptr_d;
  logic [7:0]  base_hi_q, base_hi_d;
  logic [15:0] ea_q, ea_d;
  logic [7:0]  operand_q, operand_d;
  logic        err_q, err_d;
  logic [15:0] tmo_q, tmo_d;

  logic [7:0]  zp_index;
  logic [7:0]  abs_index;
  logic [15:0] zp_addr;
  logic [15:0] ptr_next;
  logic [15:0] abs_addr;
  logic        page_cross;

  always_comb begin
    zp_index  = 8'h00;
    abs_index = 8'h00;
    case (mode_q)
      MODE_ZP_X, MODE_ZPI_X: zp_index  = x_reg;
      MODE_ABS_X:            abs_index = x_reg;
      MODE_ABS_Y, MODE_ZPI_Y: abs_index = y_reg;
      default: ;
    endcase
  end

  // The first byte feeds the zero-page path; {rdata, lo_q} is the absolute base
  // in OP_HI and the fetched pointer in PTR_HI.
  ea_calc #(.ZP_WRAP(ZP_WRAP)) u_ea_calc (
    .zp_base    (mem_rdata),
    .zp_index   (zp_index),
    .ptr        (ptr_q),
    .abs_base   ({mem_rdata, lo_q}),
    .abs_index  (abs_index),
    .zp_addr    (zp_addr),
    .ptr_next   (ptr_next),
    .abs_addr   (abs_addr),
    .page_cross (page_cross)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    lo_d      = lo_q;
    ptr_d     = ptr_q;
    base_hi_d = base_hi_q;
    ea_d      = ea_q;
    operand_d = operand_q;
    err_d     = err_q;
    tmo_d     = TMO_LOAD;
    mem_req   = 1'b0;
    mem_addr  = 16'h0000;
    pc_inc    = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d = mode;
          if (mode_legal(mode)) begin
            err_d   = 1'b0;
            state_d = S_OP_LO;
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_OP_LO: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_ack) begin
          pc_inc = 1'b1;
          lo_d   = mem_rdata;
          case (mode_q)
            MODE_IMM: begin
              operand_d = mem_rdata;
              ea_d      = 16'h0000;
              state_d   = S_DONE;
            end
            MODE_ZP, MODE_ZP_X: begin
              ea_d    = zp_addr;
              state_d = S_READ;
            end
            MODE_ZPI, MODE_ZPI_X, MODE_ZPI_Y: begin
              ptr_d   = zp_addr;
              state_d = S_PTR_LO;
            end
            default: state_d = S_OP_HI;
          endcase
        end
      end
      S_OP_HI: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_ack) begin
          pc_inc    = 1'b1;
          ea_d      = abs_addr;
          base_hi_d = mem_rdata;
          state_d   = (PENALTY_EN && page_cross) ? S_FIX : S_READ;
        end
      end
      S_PTR_LO: begin
        mem_req  = 1'b1;
        mem_addr = ptr_q;
        if (mem_ack) begin
          lo_d    = mem_rdata;
          state_d = S_PTR_HI;
        end
      end
      S_PTR_HI: begin
        mem_req  = 1'b1;
        mem_addr = ptr_next;
        if (mem_ack) begin
          ea_d      = abs_addr;
          base_hi_d = mem_rdata;
          state_d   = (PENALTY_EN && page_cross) ? S_FIX : S_READ;
        end
      end
      S_FIX: begin
        mem_req  = 1'b1;
        mem_addr = {base_hi_q, ea_q[7:0]};
        if (mem_ack) state_d = S_READ;
      end
      S_READ: begin
        mem_req  = 1'b1;
        mem_addr = ea_q;
        if (mem_ack) begin
          operand_d = mem_rdata;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Per-access watchdog: reloads whenever no access is stalled.
    if (mem_req && !mem_ack) begin
      tmo_d = tmo_q - 16'd1;
      if ((ACK_TIMEOUT != 0) && (tmo_q == 16'd0)) begin
        err_d   = 1'b1;
        state_d = S_DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mode_q    <= MODE_IMM;
      lo_q      <= 8'h00;
      ptr_q     <= 16'h0000;
      base_hi_q <= 8'h00;
      ea_q      <= 16'h0000;
      operand_q <= 8'h00;
      err_q     <= 1'b0;
      tmo_q     <= TMO_LOAD;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      lo_q      <= lo_d;
      ptr_q     <= ptr_d;
      base_hi_q <= base_hi_d;
      ea_q      <= ea_d;
      operand_q <= operand_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign err     = err_q && (state_q == S_DONE);
  assign ea      = ea_q;
  assign operand = operand_q;

endmodule

// File: doc/operand_sequencer.md
Name: operand_sequencer

Overview:
- Multi-cycle controller that resolves a 6502 addressing mode into an effective address (EA) and fetches the operand byte for ALU-class instructions (ADC family first).
- Sits between instruction_control and the memory bus.
- instruction_control supplies the decoded mode and a start pulse. The sequencer drives bus reads, requests PC increments and pulses done with EA/operand valid, which triggers the ALU load.

Parameters:
- ZP_WRAP, 1, 1 = zero-page indexed and pointer addresses wrap within page 0 (NMOS/65C02 behaviour); 0 = carry into the high byte (debug only).
- ACK_TIMEOUT, 0, 0 = wait forever for mem_ack; N>0 = abort with err after N cycles without ack.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- mode  in  4  addressing mode code (package constants)
- pc  in  16  current program counter, used for operand-byte fetches
- x_reg  in  8  X index
- y_reg  in  8  Y index
- mem_addr  out  16  read address
- mem_req  out  1  read request; held with mem_addr until ack
- mem_ack  in  1  read completes this cycle; mem_rdata valid
- mem_rdata  in  8  read data
- pc_inc  out  1  one-cycle pulse: increment PC (coincides with an acked PC fetch)
- ea  out  16  effective address (0x0000 for IMM)
- operand  out  8  fetched operand byte
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; ea/operand valid this cycle and held until next start
- err  out  1  valid with done: illegal mode or ack timeout

Behaviour:
- Reset: state=IDLE; mem_req=0, mem_addr=0, pc_inc=0, busy=0, done=0, err=0, ea=0, operand=0. Reset mid-operation drops mem_req immediately and discards the partial EA.
- States: IDLE, OP_LO, OP_HI, PTR_LO, PTR_HI, FIX, READ, DONE.
- Handshake:
  - mem_req and mem_addr are combinational from the registered state.
  - The transition happens on the edge where mem_ack=1.
  - mem_req=0 never occurs mid-wait.
- Mode paths (start through done with zero-wait ack):
  - IMM: OP_LO(read pc, data -> operand) -> DONE. 2 cycles.
  - ZP: OP_LO -> READ(ea={00,lo}) -> DONE. 3 cycles.
  - ZP_X: as ZP, ea={00,(lo+X)&FF}. 3 cycles.
  - ABS: OP_LO -> OP_HI -> READ -> DONE. 4 cycles.
  - ABS_X/ABS_Y: ea={hi,lo}+index as a 16-bit sum, wrapping at 0xFFFF. 4 cycles; 5 with the penalty feature on a page cross.
  - ZPI: OP_LO -> PTR_LO(read {00,zp}) -> PTR_HI(read {00,(zp+1)&FF}) -> READ -> DONE. 5 cycles.
  - ZPI_X: pointer base is (zp+X)&FF; the high byte is read at base+1, wrapping within page 0. 5 cycles.
  - ZPI_Y: pointer read as in ZPI, then ea = ptr+Y (16-bit). 5 cycles, +1 on page cross with the feature.
- pc_inc asserts in OP_LO and OP_HI on the ack cycle only.
- start while busy is ignored, with no queueing.
- Illegal mode code: IDLE -> DONE with err=1, no bus activity, ea/operand unchanged.
- ACK_TIMEOUT>0: a per-access counter resets on each new access; on expiry go to DONE with err=1 and deassert mem_req.

Optional Feature:
- Macro: OPERAND_SEQ_PAGE_PENALTY_EN.
- Defined: for ABS_X, ABS_Y and ZPI_Y, when the high byte of ea differs from the base high byte, insert FIX. FIX issues a dummy read at {base_hi, ea_lo}, then READ. The total is one extra cycle.
- Undefined: FIX is unreachable and there is never a penalty cycle.

Decomposition:
- Package cpu6502_pkg holds:
  - mode codes: IMM=0, ZP=1, ZP_X=2, ZPI=3, ZPI_X=4, ZPI_Y=5, ABS=6, ABS_X=7, ABS_Y=8; 9..15 illegal.
  - the state encoding enum.
  - the ADC opcode constants shared with instruction_control.
- Sub-module ea_calc: combinational zero-page wrap, 16-bit index add and page-cross flag. Keeps the FSM free of arithmetic.

Test Plan:
- IMM, pc=0x0200, rdata=0x42, zero-wait ack -> one pc_inc; done on cycle 2; operand=0x42, ea=0x0000, err=0.
- ZP_X, lo=0xF0, X=0x20 -> READ at 0x0010 (page-0 wrap); done on cycle 3.
- ZPI_X, zp=0xFE, X=0x01, mem[0xFF]=0x34, mem[0x00]=0x12 -> ea=0x1234; done on cycle 5.
- ABS_Y, base=0x12F0, Y=0x20 -> ea=0x1310. With the macro: dummy read at 0x1210, done on cycle 5. Without the macro: done on cycle 4.
- ABS with mem_ack withheld 3 cycles on OP_HI -> mem_req/mem_addr stable; done delayed by 3; start pulses during busy are ignored.
- Reset asserted during PTR_HI -> mem_req=0 immediately; after release a fresh IMM request completes normally. Mode=0xC -> done+err in 1 cycle with no mem_req.
